k580vv55_hs: RTL and testbench



---
 rtl/k580vv55_hs_if.sv | 17 +
 rtl/k580vv55_hs.sv | 212 +++++++++++++++++++++
 tb/tb_k580vv55_hs.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/k580vv55_hs_if.sv
// CPU-side I/O bus of the KR580VV55 parallel interface.
//   addr  : register select (0=A, 1=B, 2=C, 3=control)
//   we_n  : write strobe, active low, one clk per access
//   rd    : read strobe, active high, one clk per access
//   idata : write data
//   odata : read data, combinational from addr
// master = CPU / bus controller, slave = the peripheral.
interface k580vv55_hs_if;
  logic [1:0] addr;
  logic       we_n;
  logic       rd;
  logic [7:0] idata;
  logic [7:0] odata;

  modport master (output addr, we_n, rd, idata, input odata);
  modport slave  (input addr, we_n, rd, idata, output odata);
endinterface

// File: rtl/k580vv55_hs.sv
// KR580VV55 (i8255) parallel interface, Mode 0 and Mode 1 per group, with a
// live control register and strobed input/output handshakes on port C.
// Mode 2 is not supported.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : CPU register bus (addr/we_n/rd/idata/odata)
//   ipa/ipb/ipc       : port pin inputs
//   opa/opb/opc       : port output latches (opc carries handshake outputs)
//   oea/oeb           : port A/B drive enable (1 = output)
//   oec               : per-bit port C drive enable
//   intr_a/intr_b     : INTR_A (PC3) and INTR_B (PC0) mirrors
// Build option: K580VV55_SYNC_EN routes ipa/ipb/ipc through two flops
// (reset to 8'hFF) before any use; otherwise pins must be synchronous to clk.
module k580vv55_hs #(
  parameter logic [7:0] RESET_CW  = 8'h9B,
  parameter logic [7:0] RESET_OUT = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  k580vv55_hs_if.slave     bus,
  input  logic [7:0]       ipa,
  input  logic [7:0]       ipb,
  input  logic [7:0]       ipc,
  output logic [7:0]       opa,
  output logic [7:0]       opb,
  output logic [7:0]       opc,
  output logic             oea,
  output logic             oeb,
  output logic [7:0]       oec,
  output logic             intr_a,
  output logic             intr_b
);

  logic [7:0] pa_s, pb_s, pc_s;

`ifdef K580VV55_SYNC_EN
  logic [7:0] pa_meta_reg, pb_meta_reg, pc_meta_reg;
  logic [7:0] pa_sync_reg, pb_sync_reg, pc_sync_reg;
  always_ff @(posedge clk) begin
    if (reset) begin
      pa_meta_reg <= 8'hFF; pb_meta_reg <= 8'hFF; pc_meta_reg <= 8'hFF;
      pa_sync_reg <= 8'hFF; pb_sync_reg <= 8'hFF; pc_sync_reg <= 8'hFF;
    end else begin
      pa_meta_reg <= ipa; pb_meta_reg <= ipb; pc_meta_reg <= ipc;
      pa_sync_reg <= pa_meta_reg; pb_sync_reg <= pb_meta_reg; pc_sync_reg <= pc_meta_reg;
    end
  end
  assign pa_s = pa_sync_reg;
  assign pb_s = pb_sync_reg;
  assign pc_s = pc_sync_reg;
`else
  assign pa_s = ipa;
  assign pb_s = ipb;
  assign pc_s = ipc;
`endif

  // Bit 7 of a mode-set word is always 1, so only [6:0] is kept.
  logic [6:0] cw_reg;
  logic [7:0] opa_reg, opb_reg, opc_reg, la_reg, lb_reg;
  logic ibf_a_reg, obf_a_n_reg, intr_a_reg, inte_a_in_reg, inte_a_out_reg;
  logic ibf_b_reg, obf_b_n_reg, intr_b_reg, inte_b_reg;
  logic stb_a_prev_reg, ack_a_prev_reg, hs_b_prev_reg;

  logic a_m1, a_in, b_m1, b_in;
  assign a_m1 = |cw_reg[6:5];
  assign a_in = cw_reg[4];
  assign b_m1 = cw_reg[2];
  assign b_in = cw_reg[1];

  logic wr_a, wr_b, wr_c, wr_cw, rd_a, rd_b;
  assign wr_a  = !bus.we_n && (bus.addr == 2'd0);
  assign wr_b  = !bus.we_n && (bus.addr == 2'd1);
  assign wr_c  = !bus.we_n && (bus.addr == 2'd2);
  assign wr_cw = !bus.we_n && (bus.addr == 2'd3);
  assign rd_a  = bus.rd && (bus.addr == 2'd0);
  assign rd_b  = bus.rd && (bus.addr == 2'd1);

  // Edges on the strobe/acknowledge pins against last clk's sample.
  logic stb_a_fall, stb_a_rise, ack_a_fall, ack_a_rise, hs_b_fall, hs_b_rise;
  assign stb_a_fall = stb_a_prev_reg & ~pc_s[4];
  assign stb_a_rise = ~stb_a_prev_reg & pc_s[4];
  assign ack_a_fall = ack_a_prev_reg & ~pc_s[6];
  assign ack_a_rise = ~ack_a_prev_reg & pc_s[6];
  assign hs_b_fall  = hs_b_prev_reg & ~pc_s[2];
  assign hs_b_rise  = ~hs_b_prev_reg & pc_s[2];

  logic [2:0] bsr_bit;
  assign bsr_bit = bus.idata[3:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      cw_reg <= RESET_CW[6:0];
      opa_reg <= RESET_OUT; opb_reg <= RESET_OUT; opc_reg <= RESET_OUT;
      la_reg <= 8'h00; lb_reg <= 8'h00;
      ibf_a_reg <= 1'b0; obf_a_n_reg <= 1'b1; intr_a_reg <= 1'b0;
      inte_a_in_reg <= 1'b0; inte_a_out_reg <= 1'b0;
      ibf_b_reg <= 1'b0; obf_b_n_reg <= 1'b1; intr_b_reg <= 1'b0; inte_b_reg <= 1'b0;
      stb_a_prev_reg <= 1'b1; ack_a_prev_reg <= 1'b1; hs_b_prev_reg <= 1'b1;
    end else begin
      stb_a_prev_reg <= pc_s[4];
      ack_a_prev_reg <= pc_s[6];
      hs_b_prev_reg  <= pc_s[2];
      if (wr_a) opa_reg <= bus.idata;
      if (wr_b) opb_reg <= bus.idata;
      if (wr_c) opc_reg <= bus.idata;
      if (wr_cw) begin
        // A control write suppresses every handshake event in this clk.
        if (bus.idata[7]) begin
          cw_reg <= bus.idata[6:0];
          opa_reg <= 8'h00; opb_reg <= 8'h00; opc_reg <= 8'h00;
          ibf_a_reg <= 1'b0; obf_a_n_reg <= 1'b1; intr_a_reg <= 1'b0;
          inte_a_in_reg <= 1'b0; inte_a_out_reg <= 1'b0;
          ibf_b_reg <= 1'b0; obf_b_n_reg <= 1'b1; intr_b_reg <= 1'b0; inte_b_reg <= 1'b0;
        end else if (a_m1 && a_in && bsr_bit == 3'd4) begin
          inte_a_in_reg <= bus.idata[0];
        end else if (a_m1 && !a_in && bsr_bit == 3'd6) begin
          inte_a_out_reg <= bus.idata[0];
        end else if (b_m1 && bsr_bit == 3'd2) begin
          inte_b_reg <= bus.idata[0];
        end else begin
          opc_reg[bsr_bit] <= bus.idata[0];
        end
      end else begin
        // Set conditions are tested first so they win over a clear in the same clk.
        if (a_m1) begin
          if (a_in) begin
            if (stb_a_fall) begin
              la_reg <= pa_s; ibf_a_reg <= 1'b1;
            end else if (rd_a) ibf_a_reg <= 1'b0;
            if (stb_a_rise && ibf_a_reg && inte_a_in_reg) intr_a_reg <= 1'b1;
            else if (rd_a) intr_a_reg <= 1'b0;
          end else begin
            if (wr_a) obf_a_n_reg <= 1'b0;
            else if (ack_a_fall) obf_a_n_reg <= 1'b1;
            if (ack_a_rise && inte_a_out_reg) intr_a_reg <= 1'b1;
            else if (wr_a) intr_a_reg <= 1'b0;
          end
        end
        if (b_m1) begin
          if (b_in) begin
            if (hs_b_fall) begin
              lb_reg <= pb_s; ibf_b_reg <= 1'b1;
            end else if (rd_b) ibf_b_reg <= 1'b0;
            if (hs_b_rise && ibf_b_reg && inte_b_reg) intr_b_reg <= 1'b1;
            else if (rd_b) intr_b_reg <= 1'b0;
          end else begin
            if (wr_b) obf_b_n_reg <= 1'b0;
            else if (hs_b_fall) obf_b_n_reg <= 1'b1;
            if (hs_b_rise && inte_b_reg) intr_b_reg <= 1'b1;
            else if (wr_b) intr_b_reg <= 1'b0;
          end
        end
      end
    end
  end

  // Port C drive enables and output values with handshake bits substituted.
  logic [7:0] oec_c, opc_c, c_mix, c_read;
  always_comb begin
    oec_c = {{4{~cw_reg[3]}}, {4{~cw_reg[0]}}};
    opc_c = opc_reg;
    if (a_m1) begin
      oec_c[3] = 1'b1;
      opc_c[3] = intr_a_reg;
      if (a_in) begin
        oec_c[4] = 1'b0; oec_c[5] = 1'b1; opc_c[5] = ibf_a_reg;
      end else begin
        oec_c[6] = 1'b0; oec_c[7] = 1'b1; opc_c[7] = obf_a_n_reg;
      end
    end
    if (b_m1) begin
      oec_c[2] = 1'b0; oec_c[1] = 1'b1; oec_c[0] = 1'b1;
      opc_c[1] = b_in ? ibf_b_reg : obf_b_n_reg;
      opc_c[0] = intr_b_reg;
    end
  end

  // Driven C bits read back what is driven; undriven bits read the pins.
  for (genvar gi = 0; gi < 8; gi++) begin : g_cmix
    assign c_mix[gi] = oec_c[gi] ? opc_c[gi] : pc_s[gi];
  end

  // Strobe/ack inputs read back as their INTE flop.
  always_comb begin
    c_read = c_mix;
    if (a_m1) begin
      if (a_in) c_read[4] = inte_a_in_reg;
      else      c_read[6] = inte_a_out_reg;
    end
    if (b_m1) c_read[2] = inte_b_reg;
  end

  always_comb begin
    bus.odata = 8'hFF;
    case (bus.addr)
      2'd0: bus.odata = (a_m1 && a_in) ? la_reg : (a_in ? pa_s : opa_reg);
      2'd1: bus.odata = (b_m1 && b_in) ? lb_reg : (b_in ? pb_s : opb_reg);
      2'd2: bus.odata = c_read;
      default: bus.odata = 8'hFF;
    endcase
  end

  assign opa    = opa_reg;
  assign opb    = opb_reg;
  assign opc    = opc_c;
  assign oea    = ~cw_reg[4];
  assign oeb    = ~cw_reg[1];
  assign oec    = oec_c;
  assign intr_a = intr_a_reg;
  assign intr_b = intr_b_reg;

endmodule

// File: tb/tb_k580vv55_hs.sv
module tb_k580vv55_hs;

`ifdef K580VV55_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [7:0] ipa, ipb, ipc;
  logic [7:0] opa, opb, opc, oec;
  logic oea, oeb, intr_a, intr_b;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  k580vv55_hs_if bus();

  k580vv55_hs dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ipa(ipa), .ipb(ipb), .ipc(ipc),
    .opa(opa), .opb(opb), .opc(opc),
    .oea(oea), .oeb(oeb), .oec(oec),
    .intr_a(intr_a), .intr_b(intr_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (SL) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.addr = a; bus.idata = d; bus.we_n = 1'b0;
    tick();
    bus.we_n = 1'b1;
    $display("wr  addr=%0d data=%02h", a, d);
  endtask

  task automatic rdp(input logic [1:0] a);
    bus.addr = a; bus.rd = 1'b1;
    #1;
    $display("rd  addr=%0d data=%02h", a, bus.odata);
    tick();
    bus.rd = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, input string tag, input logic [7:0] exp);
    bus.addr = a;
    #1;
    chk(tag, bus.odata, exp);
  endtask

  // Reference model state for the random Mode 0 phase.
  logic [7:0] m_cw, m_opa, m_opb, m_opc, mask_c, r, d, byte_v;
  int op;

  initial begin
    reset = 1'b1; ipa = 8'h00; ipb = 8'h00; ipc = 8'hFF;
    bus.addr = 2'd3; bus.we_n = 1'b1; bus.rd = 1'b0; bus.idata = 8'h00;
    tick(); tick();
    reset = 1'b0;
    settle();

    // reset state
    chk("rst_opa", opa, 8'hFF);
    chk("rst_opb", opb, 8'hFF);
    chk("rst_opc", opc, 8'hFF);
    chk("rst_oea", {7'd0, oea}, 8'h00);
    chk("rst_oeb", {7'd0, oeb}, 8'h00);
    chk("rst_oec", oec, 8'h00);
    chk("rst_intr_a", {7'd0, intr_a}, 8'h00);
    chk("rst_intr_b", {7'd0, intr_b}, 8'h00);
    peek(2'd3, "rst_rd_cw", 8'hFF);

    // Mode 0 all outputs
    wr(2'd3, 8'h80); wr(2'd0, 8'h5A); wr(2'd1, 8'hC3);
    chk("m0_opa", opa, 8'h5A);
    chk("m0_opb", opb, 8'hC3);
    chk("m0_opc", opc, 8'h00);
    chk("m0_oea", {7'd0, oea}, 8'h01);
    chk("m0_oeb", {7'd0, oeb}, 8'h01);
    chk("m0_oec", oec, 8'hFF);
    peek(2'd0, "m0_rd_a", 8'h5A);

    // Mode 1 strobed input on A
    wr(2'd3, 8'hB0); wr(2'd3, 8'h09);
    chk("m1i_oec", oec, 8'hEF);
    ipa = 8'h3C; settle();
    ipc[4] = 1'b0; settle(); tick(); tick();
    chk("m1i_ibf_set", {7'd0, opc[5]}, 8'h01);
    chk("m1i_intr_low", {7'd0, intr_a}, 8'h00);
    ipc[4] = 1'b1; settle(); tick();
    chk("m1i_intr_set", {7'd0, intr_a}, 8'h01);
    ipa = 8'h00; settle();
    peek(2'd0, "m1i_rd_latch", 8'h3C);
    rdp(2'd0);
    chk("m1i_intr_clr", {7'd0, intr_a}, 8'h00);
    chk("m1i_ibf_clr", {7'd0, opc[5]}, 8'h00);

    // Mode 1 strobed output on A
    wr(2'd3, 8'hA0); wr(2'd3, 8'h0D);
    chk("m1o_obf_idle", {7'd0, opc[7]}, 8'h01);
    wr(2'd0, 8'h77);
    chk("m1o_obf_set", {7'd0, opc[7]}, 8'h00);
    chk("m1o_opa", opa, 8'h77);
    ipc[6] = 1'b0; settle(); tick();
    chk("m1o_obf_ack", {7'd0, opc[7]}, 8'h01);
    chk("m1o_intr_low", {7'd0, intr_a}, 8'h00);
    ipc[6] = 1'b1; settle(); tick();
    chk("m1o_intr_set", {7'd0, intr_a}, 8'h01);

    // Mode 1 output on B: write coinciding with ACK fall keeps OBF asserted
    wr(2'd3, 8'h84);
    ipc[2] = 1'b0; settle();
    wr(2'd1, 8'h11);
    chk("m1b_obf_win", {7'd0, opc[1]}, 8'h00);
    tick();
    chk("m1b_obf_hold", {7'd0, opc[1]}, 8'h00);
    wr(2'd3, 8'h0B);
    chk("m1b_bsr_pc5", {7'd0, opc[5]}, 8'h01);
    ipc[2] = 1'b1; settle(); tick();
    chk("m1b_no_inte", {7'd0, intr_b}, 8'h00);
    wr(2'd3, 8'h05); wr(2'd1, 8'h22);
    chk("m1b_obf2", {7'd0, opc[1]}, 8'h00);
    ipc[2] = 1'b0; settle(); tick();
    chk("m1b_obf2_ack", {7'd0, opc[1]}, 8'h01);
    ipc[2] = 1'b1; settle(); tick();
    chk("m1b_intr", {7'd0, intr_b}, 8'h01);

    // pin-to-odata latency in Mode 0 input
    wr(2'd3, 8'h9B);
    ipa = 8'h00; settle(); tick();
    bus.addr = 2'd0;
    ipa = 8'hAA;
    for (int k = 0; k < SL; k++) begin
      peek(2'd0, "lat_old", 8'h00);
      tick();
    end
    peek(2'd0, "lat_new", 8'hAA);

    // random Mode 1 input transfers: read must return the byte present at the strobe fall
    wr(2'd3, 8'hB0); wr(2'd3, 8'h09);
    ipc = 8'hFF; settle(); tick();
    for (int i = 0; i < 6; i++) begin
      byte_v = 8'($urandom);
      ipa = byte_v; settle();
      ipc[4] = 1'b0; settle(); tick();
      ipa = 8'($urandom);
      ipc[4] = 1'b1; settle(); tick();
      chk("rnd1_intr", {7'd0, intr_a}, 8'h01);
      peek(2'd0, "rnd1_rd", byte_v);
      rdp(2'd0);
      chk("rnd1_intr_clr", {7'd0, intr_a}, 8'h00);
    end

    // random Mode 0 traffic against a register/pin model
    m_cw = 8'h00; m_opa = 8'h00; m_opb = 8'h00; m_opc = 8'h00;
    for (int i = 0; i < 40; i++) begin
      op = (i == 0) ? 4 : int'($urandom_range(0, 4));
      r = 8'($urandom);
      d = 8'($urandom);
      case (op)
        0: begin wr(2'd0, d); m_opa = d; end
        1: begin wr(2'd1, d); m_opb = d; end
        2: begin wr(2'd2, d); m_opc = d; end
        3: begin
          wr(2'd3, {4'd0, r[2:0], d[0]});
          m_opc[r[2:0]] = d[0];
        end
        default: begin
          m_cw = {1'b1, 2'b00, r[4], r[3], 1'b0, r[1], r[0]};
          wr(2'd3, m_cw);
          m_opa = 8'h00; m_opb = 8'h00; m_opc = 8'h00;
        end
      endcase
      ipa = 8'($urandom); ipb = 8'($urandom); ipc = 8'($urandom);
      settle();
      mask_c = {(m_cw[3] ? 4'h0 : 4'hF), (m_cw[0] ? 4'h0 : 4'hF)};
      peek(2'd0, "rnd0_a", m_cw[4] ? ipa : m_opa);
      peek(2'd1, "rnd0_b", m_cw[1] ? ipb : m_opb);
      peek(2'd2, "rnd0_c", (m_opc & mask_c) | (ipc & ~mask_c));
      chk("rnd0_opc", opc, m_opc);
      chk("rnd0_oec", oec, mask_c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
